// File: rtl/dlya_chain_monitor.sv
// dlya_chain_monitor: launch-and-capture monitor for a chain of dlya delay cells.
// Drives an edge into the first cell, samples all taps one clock later, and
// accumulates the tap count over RUNS launches.
// Optional feature: define DLYA_MON_BUBBLE_CHK_EN to count the thermometer length
// and flag bubbles. Without it, the per-run count is the popcount of the taps.
module dlya_chain_monitor #(
    parameter int unsigned TAPS = 8,
    parameter int unsigned RUNS = 4,
    parameter int unsigned TMO  = 15
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic                            START,
    input  logic [TAPS-1:0]                 TAP,
    output logic                            LAUNCH,
    output logic                            BUSY,
    output logic                            DONE,
    output logic [$clog2(TAPS*RUNS+1)-1:0]  CODE,
    output logic                            ERR
);

    localparam int unsigned CW    = $clog2(TAPS*RUNS+1);
    localparam int unsigned RUN_W = (RUNS > 1) ? $clog2(RUNS) : 1;
    localparam int unsigned TMO_W = $clog2(TMO+1);

    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(RUNS-1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO-1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FIRE  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t           state;
    logic [RUN_W-1:0] run_cnt;
    logic [TMO_W-1:0] tmo_cnt;
    logic [CW-1:0]    acc;
    logic [CW-1:0]    run_count;

`ifdef DLYA_MON_BUBBLE_CHK_EN
    logic bubble;
    logic bubble_q;
    logic seen_zero;

    // Per-run count: thermometer length from TAP[0]; any 1 above the first 0 is a bubble
    always_comb begin
        run_count = '0;
        bubble    = 1'b0;
        seen_zero = 1'b0;
        for (int i = 0; i < int'(TAPS); i++) begin
            if (!TAP[i]) begin
                seen_zero = 1'b1;
            end else if (seen_zero) begin
                bubble = 1'b1;
            end else begin
                run_count = run_count + CW'(1);
            end
        end
    end
`else
    // Per-run count: popcount of the sampled taps
    always_comb begin
        run_count = '0;
        for (int i = 0; i < int'(TAPS); i++) begin
            run_count = run_count + CW'(TAP[i]);
        end
    end
`endif

    // Measurement sequencer; TAP is sampled straight into the state update on purpose
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= ST_IDLE;
            LAUNCH  <= 1'b0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
            CODE    <= '0;
            ERR     <= 1'b0;
            run_cnt <= '0;
            tmo_cnt <= '0;
            acc     <= '0;
`ifdef DLYA_MON_BUBBLE_CHK_EN
            bubble_q <= 1'b0;
`endif
        end else begin
            DONE <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (START) begin
                        state   <= ST_FIRE;
                        LAUNCH  <= 1'b1;
                        BUSY    <= 1'b1;
                        acc     <= '0;
                        run_cnt <= '0;
                        tmo_cnt <= '0;
`ifdef DLYA_MON_BUBBLE_CHK_EN
                        bubble_q <= 1'b0;
`endif
                    end
                end
                ST_FIRE: begin
                    // Capture edge: the edge has had exactly one period to propagate
                    LAUNCH  <= 1'b0;
                    acc     <= acc + run_count;
                    tmo_cnt <= '0;
                    state   <= ST_DRAIN;
`ifdef DLYA_MON_BUBBLE_CHK_EN
                    bubble_q <= bubble_q | bubble;
`endif
                end
                ST_DRAIN: begin
                    if (TAP == '0) begin
                        tmo_cnt <= '0;
                        if (run_cnt == RUN_LAST) begin
                            state <= ST_DONE;
                            DONE  <= 1'b1;
                            BUSY  <= 1'b0;
                            CODE  <= acc;
`ifdef DLYA_MON_BUBBLE_CHK_EN
                            ERR   <= bubble_q;
`else
                            ERR   <= 1'b0;
`endif
                        end else begin
                            run_cnt <= run_cnt + RUN_W'(1);
                            state   <= ST_FIRE;
                            LAUNCH  <= 1'b1;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        // Chain never returned to zero: abort with no valid code
                        tmo_cnt <= '0;
                        state   <= ST_DONE;
                        DONE    <= 1'b1;
                        BUSY    <= 1'b0;
                        CODE    <= '0;
                        ERR     <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dlya_chain_monitor.sv
// Testbench for dlya_chain_monitor: directed and randomized measurements checked
// cycle by cycle against a schedule and code derived from the measurement rules.
// Honours DLYA_MON_BUBBLE_CHK_EN the same way as the design.
module tb_dlya_chain_monitor;

    localparam int unsigned TAPS = 8;
    localparam int unsigned RUNS = 4;
    localparam int unsigned TMO  = 15;
    localparam int unsigned CW   = $clog2(TAPS*RUNS+1);

    logic            clk;
    logic            rst;
    logic            start;
    logic [TAPS-1:0] tap;
    logic            launch;
    logic            busy;
    logic            done;
    logic [CW-1:0]   code;
    logic            err;

    int checks = 0;
    int errors = 0;

    logic [TAPS-1:0] cap_v   [RUNS];
    int              drain_v [RUNS];
    int              last_code;
    logic            last_err;

    dlya_chain_monitor #(.TAPS(TAPS), .RUNS(RUNS), .TMO(TMO)) dut (
        .CLK    (clk),
        .RST    (rst),
        .START  (start),
        .TAP    (tap),
        .LAUNCH (launch),
        .BUSY   (busy),
        .DONE   (done),
        .CODE   (code),
        .ERR    (err)
    );

    always #5 clk = ~clk;

    // Advance one clock and settle just after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Taps the edge reached in one run
    function automatic int model_count(input logic [TAPS-1:0] v);
`ifdef DLYA_MON_BUBBLE_CHK_EN
        int n = 0;
        while (n < int'(TAPS) && v[n] === 1'b1) n++;
        return n;
`else
        return $countones(v);
`endif
    endfunction

`ifdef DLYA_MON_BUBBLE_CHK_EN
    // A clean capture is exactly a run of ones from bit 0
    function automatic bit model_bubble(input logic [TAPS-1:0] v);
        logic [31:0] mask;
        mask = (32'd1 << model_count(v)) - 32'd1;
        return mask[TAPS-1:0] != v;
    endfunction
`endif

    task automatic expect_idle(input string tag);
        chk({tag, "_launch"}, 32'(launch), 0);
        chk({tag, "_busy"},   32'(busy),   0);
        chk({tag, "_done"},   32'(done),   0);
        chk({tag, "_code"},   32'(code),   32'(last_code));
        chk({tag, "_err"},    32'(err),    32'(last_err));
    endtask

    // One full measurement using cap_v/drain_v; noise keeps START high throughout
    task automatic measure(input bit noise);
        int exp_code;
        bit exp_err;
        bit abort;
        bit finished;
        exp_code = 0;
        exp_err  = 1'b0;
        abort    = 1'b0;
        for (int r = 0; r < int'(RUNS); r++) begin
            if (drain_v[r] >= int'(TMO)) begin
                abort = 1'b1;
                break;
            end
            exp_code += model_count(cap_v[r]);
`ifdef DLYA_MON_BUBBLE_CHK_EN
            if (model_bubble(cap_v[r])) exp_err = 1'b1;
`endif
        end
        if (abort) begin
            exp_code = 0;
            exp_err  = 1'b1;
        end

        start = 1'b1;
        step();
        chk("start_launch", 32'(launch), 1);
        chk("start_busy",   32'(busy),   1);
        chk("start_done",   32'(done),   0);
        start = noise;

        finished = 1'b0;
        for (int r = 0; r < int'(RUNS) && !finished; r++) begin
            tap = cap_v[r];
            step();
            chk("capture_launch", 32'(launch), 0);
            chk("capture_busy",   32'(busy),   1);
            chk("capture_code",   32'(code),   32'(last_code));
            for (int j = 0; j < drain_v[r] && !finished; j++) begin
                tap = TAPS'($urandom_range(1, (1 << TAPS) - 1));
                step();
                if (j == int'(TMO) - 1) begin
                    finished = 1'b1;
                    chk("abort_done",   32'(done),   1);
                    chk("abort_busy",   32'(busy),   0);
                    chk("abort_launch", 32'(launch), 0);
                    chk("abort_code",   32'(code),   0);
                    chk("abort_err",    32'(err),    1);
                end else begin
                    chk("drain_launch", 32'(launch), 0);
                    chk("drain_busy",   32'(busy),   1);
                    chk("drain_done",   32'(done),   0);
                end
            end
            if (!finished) begin
                tap = '0;
                step();
                if (r == int'(RUNS) - 1) begin
                    finished = 1'b1;
                    chk("end_done",   32'(done),   1);
                    chk("end_busy",   32'(busy),   0);
                    chk("end_launch", 32'(launch), 0);
                    chk("end_code",   32'(code),   32'(exp_code));
                    chk("end_err",    32'(err),    32'(exp_err));
                end else begin
                    chk("refire_launch", 32'(launch), 1);
                    chk("refire_busy",   32'(busy),   1);
                    chk("refire_done",   32'(done),   0);
                end
            end
        end

        last_code = exp_code;
        last_err  = exp_err;
        tap = '0;
        step();
        expect_idle("after_done");
        start = 1'b0;
    endtask

    task automatic fill(input logic [TAPS-1:0] c0, input logic [TAPS-1:0] cn, input int d);
        for (int r = 0; r < int'(RUNS); r++) begin
            cap_v[r]   = (r == 0) ? c0 : cn;
            drain_v[r] = d;
        end
    endtask

    initial begin
        logic [8:0] th;
        clk       = 1'b0;
        rst       = 1'b1;
        start     = 1'b0;
        tap       = '0;
        last_code = 0;
        last_err  = 1'b0;

        step();
        expect_idle("reset");
        rst = 1'b0;
        step();
        expect_idle("idle_quiet");

        // Short thermometer each run, fast drain
        fill(8'b0000_0111, 8'b0000_0111, 0);
        measure(1'b0);

        // Bubble in the first capture; START held high through BUSY and DONE
        fill(8'b0000_1011, 8'b0000_0000, 0);
        measure(1'b1);

        // Chain stuck non-zero: timeout abort
        fill(8'h01, 8'h01, 20);
        measure(1'b0);

        // Drain taking exactly TMO-1 extra cycles is still legal
        fill(8'h0f, 8'h01, int'(TMO) - 1);
        measure(1'b0);

        // Reset while LAUNCH is high
        start = 1'b1;
        step();
        chk("prerst_launch", 32'(launch), 1);
        start = 1'b0;
        rst   = 1'b1;
        step();
        last_code = 0;
        last_err  = 1'b0;
        expect_idle("midfire_reset");
        rst = 1'b0;
        fill(8'b0011_1111, 8'b0000_0001, 1);
        measure(1'b0);

        // Randomized measurements
        for (int n = 0; n < 25; n++) begin
            for (int r = 0; r < int'(RUNS); r++) begin
                if ($urandom_range(0, 1) == 0) begin
                    th = (9'd1 << $urandom_range(0, TAPS)) - 9'd1;
                    cap_v[r] = th[TAPS-1:0];
                end else begin
                    cap_v[r] = TAPS'($urandom);
                end
                drain_v[r] = ($urandom_range(0, 11) == 0) ? int'($urandom_range(TMO, TMO + 3))
                                                          : int'($urandom_range(0, 3));
            end
            measure(1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dlya_chain_monitor.md
# dlya_chain_monitor

Launch-and-capture monitor for a chain of delay cells of the 9-track 5V library (same dlya family). It drives an edge into the first cell's I input and samples every cell's Z output one clock later. It repeats the launch RUNS times and accumulates the number of taps the edge reached, giving a delay-versus-clock-period figure for on-chip characterisation. It sits directly upstream of the delay chain, feeding its input, and directly downstream of it, consuming its outputs.

## Interface
- TAPS, 8: number of delay cells monitored; legal range 2..32.
- RUNS, 4: launches accumulated per measurement; legal range 1..16.
- TMO, 15: maximum DRAIN cycles allowed before abort; legal range 1..255.
- CLK  input  1  Sole clock; all state updates on rising edge.
- RST  input  1  Reset: synchronous, active-high; outputs take reset values at the first CLK edge with RST=1.
- START  input  1  Measurement request; sampled only in IDLE.
- TAP  input  TAPS  Z outputs of the chain; bit 0 is the first cell.
- LAUNCH  output  1  Registered drive to I of the first cell.
- BUSY  output  1  High while a measurement is in progress.
- DONE  output  1  One-cycle completion pulse.
- CODE  output  $clog2(TAPS*RUNS+1)  Accumulated tap count, held between measurements.
- ERR  output  1  Error flag for the last measurement, held with CODE.

## Operation
- Reset values: LAUNCH=0, BUSY=0, DONE=0, CODE=0, ERR=0, state=IDLE, run counter=0, accumulator=0, timeout counter=0.
- IDLE: if START=1, go to FIRE, clear the accumulator and run counter, and set BUSY=1. Otherwise stay in IDLE.
- FIRE: LAUNCH=1 for exactly one cycle. Next state is CAPTURE.
- CAPTURE edge:
  - Register TAP, compute the per-run tap count, and add it to the accumulator.
  - Set LAUNCH=0 and go to DRAIN.
- DRAIN, on each edge:
  - If TAP==0: increment the run counter and clear the timeout counter. If the run counter was RUNS-1, go to DONE; otherwise go to FIRE.
  - If TAP!=0: increment the timeout counter. When the count reaches TMO, abort to DONE with ERR=1 and CODE=0.
- DONE state (one cycle):
  - DONE=1 and BUSY=0.
  - CODE and ERR load at the edge entering DONE.
  - Next state is IDLE.
- TAP is sampled by one flop level with no synchroniser. Sampling against CLK is the measurement, so no extra stages are permitted.
- START while BUSY=1 or DONE=1 is ignored and is not queued.
- RST=1 mid-measurement aborts: the next edge forces LAUNCH=0 and all reset values. The chain then drains naturally.
- Accumulator width is fixed at the CODE width; overflow is impossible by construction.

## Timing
- START=1 sampled at edge n: LAUNCH=1 and BUSY=1 from edge n.
- Capture at edge n+1, which also sets LAUNCH=0.
- Minimum run length is 2 cycles, when TAP==0 at the first DRAIN edge.
- With fast drain, DONE is high for the cycle after edge n+2·RUNS, and BUSY falls at the same edge.
- START may be re-issued in the cycle DONE is high. It is ignored then and accepted one cycle later in IDLE.
- Each DRAIN cycle with TAP!=0 adds 1 cycle. Abort occurs at the TMO-th such edge within one run.

## Configuration
- Macro DLYA_MON_BUBBLE_CHK_EN controls bubble checking.
- Defined:
  - The per-run count is the number of leading ones from TAP[0] (thermometer length).
  - Any 1 above the first 0 in the captured TAP sets a sticky bubble flag. The flag is reported as ERR=1 at DONE, with CODE still valid.
- Undefined:
  - The per-run count is the popcount of the captured TAP.
  - ERR is set only by timeout.

## Test plan
- Reset mid-FIRE with RST=1 for 1 cycle: next edge LAUNCH=0, BUSY=0, CODE=0, ERR=0, state IDLE; a new START is accepted.
- TAPS=8, RUNS=4, TAP model returns 8'b0000_0111 at capture and 0 in DRAIN:
  - DONE pulses after edge n+8.
  - CODE=12, ERR=0.
  - LAUNCH is high exactly at cycles n, n+2, n+4, n+6.
- TAP held at 8'h01 through DRAIN with TMO=15: DONE=1, ERR=1, CODE=0 after 15 DRAIN cycles; BUSY falls with DONE.
- Captured TAP=8'b0000_1011 for RUNS=1:
  - With DLYA_MON_BUBBLE_CHK_EN: CODE=2, ERR=1.
  - Without it: CODE=3, ERR=0.
- START pulsed high during BUSY and during the DONE cycle: no restart, CODE unchanged. START one cycle after DONE starts a new measurement.
